// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF Rx synchroniser, 3-sample majority vote,
// runtime frame format, parity/framing flags and a first-word-fall-through FIFO.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line idle, waiting for an armed, enabled start edge
// S_START  | start bit window; a majority of 1 rejects it as a glitch
// S_DATA   | NBits data bits, LSB first, each committed at window end
// S_PARITY | parity bit, compared against the received data
// S_STOP1  | first stop bit; completes the frame when only one is used
// S_STOP2  | second stop bit; completes the frame
module uart_rx_param #(
    parameter int DATA_MAX   = 9,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Rx,
    input  logic                Tick,
    input  logic                RxEn,
    input  logic [3:0]          NBits,
    input  logic [1:0]          Parity,
    input  logic                StopBits,
    output logic [DATA_MAX-1:0] RxData,
    output logic                ParityErr,
    output logic                FrameErr,
    output logic                RxValid,
    input  logic                RxReady,
    output logic                Overrun,
    output logic                Busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_MAX + 2;
    localparam logic [CW-1:0] C_S0  = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] C_S1  = CW'(OVERSAMPLE/2);
    localparam logic [CW-1:0] C_S2  = CW'(OVERSAMPLE/2 + 1);
    localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    NB_MAX = 4'(DATA_MAX);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_rx_meta, r_rx_sync;
    logic [CW-1:0]       r_cnt;
    logic                r_s0, r_s1, r_bit;
    logic [DATA_MAX-1:0] r_data;
    logic [3:0]          r_bitidx;
    logic [3:0]          r_nbits;
    logic [1:0]          r_par;
    logic                r_stop2;
    logic                r_perr, r_ferr;
    logic                r_armed;
    logic                r_overrun;

    logic                w_maj, w_at_s2, w_at_end;
    logic                w_par_en, w_par_calc;
    logic                w_start;
    logic                w_push, w_frame_ferr;
    logic [3:0]          w_nbits_clamped;

    logic [EW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [AW:0]         r_count;
    logic                w_full, w_pop, w_wr;
    logic [EW-1:0]       w_head;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Majority is only meaningful on the third-sample Tick, where the live bit is the third vote.
    assign w_maj      = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
    assign w_at_s2    = Tick && (r_cnt == C_S2);
    assign w_at_end   = Tick && (r_cnt == C_END);
    assign w_par_en   = (r_par == 2'b01) || (r_par == 2'b10);
    assign w_par_calc = (^r_data) ^ (r_par == 2'b10);
    assign w_start    = Tick && !r_rx_sync && RxEn && r_armed;
    assign w_frame_ferr = r_ferr | ~w_maj;

    always_comb begin
        w_nbits_clamped = NBits;
        if (NBits < 4'd5)
            w_nbits_clamped = 4'd5;
        else if (NBits > NB_MAX)
            w_nbits_clamped = NB_MAX;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_START;
            S_START: begin
                if (w_at_s2 && w_maj)
                    w_state_nxt = S_IDLE;
                else if (w_at_end)
                    w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_at_end && (r_bitidx == r_nbits - 4'd1))
                    w_state_nxt = w_par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: if (w_at_end) w_state_nxt = S_STOP1;
            S_STOP1: begin
                if (w_at_s2 && !r_stop2) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_at_end && r_stop2) begin
                    w_state_nxt = S_STOP2;
                end
            end
            S_STOP2: begin
                if (w_at_s2) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && !RxEn) begin
            w_push      = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt    <= '0;
            r_s0     <= 1'b1;
            r_s1     <= 1'b1;
            r_bit    <= 1'b1;
            r_data   <= '0;
            r_bitidx <= '0;
            r_nbits  <= 4'd8;
            r_par    <= 2'b00;
            r_stop2  <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_start) begin
                r_cnt    <= '0;
                r_data   <= '0;
                r_bitidx <= '0;
                r_perr   <= 1'b0;
                r_ferr   <= 1'b0;
                r_nbits  <= w_nbits_clamped;
                r_par    <= Parity;
                r_stop2  <= StopBits;
            end
        end else if (Tick) begin
            r_cnt <= (r_cnt == C_END) ? '0 : r_cnt + 1'b1;
            if (r_cnt == C_S0)
                r_s0 <= r_rx_sync;
            if (r_cnt == C_S1)
                r_s1 <= r_rx_sync;
            if (r_cnt == C_S2) begin
                r_bit <= w_maj;
                if (r_state == S_STOP1)
                    r_ferr <= r_ferr | ~w_maj;
            end
            if (r_cnt == C_END) begin
                if (r_state == S_DATA) begin
                    r_data   <= r_data | (DATA_MAX'(r_bit) << r_bitidx);
                    r_bitidx <= r_bitidx + 4'd1;
                end
                if (r_state == S_PARITY)
                    r_perr <= (r_bit != w_par_calc);
            end
        end
    end

    // A framing error usually means a break; wait for the line to go idle before re-arming.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_armed <= 1'b1;
        else if (w_push && w_frame_ferr)
            r_armed <= 1'b0;
        else if (Tick && r_rx_sync)
            r_armed <= 1'b1;
    end

    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = RxValid && RxReady;
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge Clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= {r_data, r_perr, w_frame_ferr};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push && w_full && !w_pop;
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign RxValid   = (r_count != '0);
    assign RxData    = RxValid ? w_head[EW-1:2] : '0;
    assign ParityErr = RxValid ? w_head[1] : 1'b0;
    assign FrameErr  = RxValid ? w_head[0] : 1'b0;
    assign Overrun   = r_overrun;
    assign Busy      = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. It is the successor to the team's fixed-format RS-232 receiver and sits between the pad-side Rx line and the servo command parser.
- Adds runtime-selectable frame format, 3-sample majority voting, false-start rejection, parity and framing error flags, and an output FIFO with a valid/ready handshake.
- Fully synchronous to Clk. Tick is a clock enable, not a clock.

Parameters:
DATA_MAX, 9, widest supported data field in bits (legal range 5..9)
OVERSAMPLE, 16, Tick pulses per bit period (even, >= 8)
FIFO_DEPTH, 4, receive FIFO entries (power of two, >= 2)

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
Rx  in  1  serial line, idle high, asynchronous to Clk
Tick  in  1  one-Clk-wide pulse at OVERSAMPLE x baud
RxEn  in  1  receiver enable
NBits  in  4  data bits per frame (5..DATA_MAX)
Parity  in  2  00 none, 01 even, 10 odd, 11 none
StopBits  in  1  0 = one stop bit, 1 = two stop bits
RxData  out  DATA_MAX  head-of-FIFO data, right-justified, upper bits zero
ParityErr  out  1  head-of-FIFO parity error flag
FrameErr  out  1  head-of-FIFO framing error flag
RxValid  out  1  FIFO not empty
RxReady  in  1  consumer accepts head entry
Overrun  out  1  one-Clk pulse when a completed frame is dropped
Busy  out  1  high while a frame is in progress (state not IDLE)

Behaviour:
Reset and resynchronisation
- Reset values: state IDLE, FIFO empty, all outputs 0.
- Rx passes through a 2-FF synchroniser; both flops reset to 1. All references to Rx below mean the synchronised value.

Bit counter and sampling
- Counter cnt runs 0..OVERSAMPLE-1 and advances only on Tick. Each bit window starts at cnt=0.
- Samples are taken at cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the three samples.

State machine: IDLE, START, DATA, PARITY, STOP1, STOP2
- IDLE -> START on a Tick with Rx=0, RxEn=1 and armed=1; cnt cleared to 0. NBits, Parity and StopBits are latched at this point; changes mid-frame are ignored.
- NBits clamp: values below 5 are treated as 5, values above DATA_MAX as DATA_MAX.
- START: if the majority is 1, the start is false; return to IDLE and push nothing. Otherwise go to DATA at window end (cnt=OVERSAMPLE-1).
- DATA: receive NBits bits, LSB first, each bit at its window end. Then go to PARITY if parity is enabled, else STOP1.
- PARITY: compare the received bit with XOR(data) for even, or ~XOR(data) for odd. A mismatch sets perr.
- STOP1 and STOP2: a majority of 0 sets ferr. STOP2 is visited only when StopBits=1.
- Frame completion happens on the Tick where cnt=OVERSAMPLE/2+1 of the last stop bit, not at window end, so the next start edge can be caught early. On completion, push {data, perr, ferr} and return to IDLE.

Arming after framing errors
- armed is 1 out of reset.
- armed clears when a frame is pushed with ferr=1 (break or line fault).
- armed sets again when Rx=1 is seen on any Tick.

RxEn
- RxEn=0 in IDLE blocks start detection.
- RxEn falling mid-frame aborts the frame: return to IDLE, push nothing.
- FIFO drain is unaffected by RxEn.

FIFO
- First-word-fall-through: RxData, ParityErr and FrameErr show the head entry whenever RxValid=1, and are 0 when the FIFO is empty.
- Pop occurs on a Clk edge with RxValid and RxReady both high.
- A push appears on RxValid on the next Clk (latency 1 Clk from the completing Tick).
- Push when full without a simultaneous pop: the frame is dropped, Overrun pulses for 1 Clk and FIFO contents are unchanged.
- Push and pop in the same Clk while full: both succeed and occupancy is unchanged.
- Push and pop in the same Clk while empty: the push is stored and RxValid rises the next Clk.
- Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- 8N1 0xA5 at OVERSAMPLE=16, RxReady=1 -> RxValid for 1 Clk with RxData=0x0A5, ParityErr=0, FrameErr=0; Busy low afterwards.
- 7E1, send 0x41 with parity bit 1 (wrong) -> RxData=0x041, ParityErr=1. Repeat with parity bit 0 -> ParityErr=0.
- 8N2, 0x3C with second stop bit low -> FrameErr=1. The next start low is ignored until Rx is held high for at least 1 Tick; after that, 0x55 is received correctly.
- 4-Tick low glitch on idle line -> no push, Busy returns to 0. A single-Tick low spike at sample 7 inside a data bit of 0xFF -> 0xFF received (majority vote).
- RxReady=0, send 5 frames 0x01..0x05 with FIFO_DEPTH=4 -> Overrun pulses once, on frame 5. Draining returns 0x01..0x04 in order; RxValid then falls.
- 9O1, 0x1FF -> RxData=0x1FF, ParityErr=0. Drop RxEn during bit 3 of the next frame -> nothing pushed, FSM returns to IDLE.
